// File: rtl/cam_bringup_seq.sv
// -----------------------------------------------------------------------------
// cam_bringup_seq
//   Supervised camera bring-up sequencer. It powers the camera, releases the
//   I2C master reset, requests register init from the I2C config block, and
//   waits for the result. On an init error or timeout it power-cycles the
//   camera and retries up to MAX_RETRY times, then latches a fault.
//   All timing is counted in 400kHz `tick` strobes.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   tick         in   400kHz strobe, one clk wide (timebase)
//   enable       in   level: 1 = bring camera up and keep it up
//   init_done    in   pulse: register init finished OK
//   init_err     in   pulse: NACK/abort during register init
//   cam_en       out  camera power/enable drive
//   i2c_areset_n out  I2C master reset, active-low
//   init_start   out  one-cycle pulse on the first cycle in INIT
//   cam_ready    out  camera initialised, streaming allowed
//   fault        out  retries exhausted; held until enable drops
//   retry_cnt    out  retries consumed in the current bring-up
//   state_o      out  current state code (debug/ILA)
// -----------------------------------------------------------------------------
module cam_bringup_seq #(
  parameter int PWR_DLY_TICKS  = 800000,
  parameter int I2C_DLY_TICKS  = 800000,
  parameter int INIT_TMO_TICKS = 400000,
  parameter int OFF_TICKS      = 40000,
  parameter int MAX_RETRY      = 3,
  localparam int MAX_A = (PWR_DLY_TICKS > I2C_DLY_TICKS) ? PWR_DLY_TICKS : I2C_DLY_TICKS,
  localparam int MAX_B = (INIT_TMO_TICKS > OFF_TICKS) ? INIT_TMO_TICKS : OFF_TICKS,
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B,
  localparam int TW    = $clog2(MAX_T) + 1,
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          enable,
  input  logic          init_done,
  input  logic          init_err,
  output logic          cam_en,
  output logic          i2c_areset_n,
  output logic          init_start,
  output logic          cam_ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PWR_ON  = 3'd1,
    S_I2C_REL = 3'd2,
    S_INIT    = 3'd3,
    S_RUN     = 3'd4,
    S_PWR_OFF = 3'd5,
    S_FAULT   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          cam_en_q, i2c_rel_q, start_q, ready_q, fault_q;

  // A wait of N ticks ends on the edge that samples the Nth tick since entry.
  logic pwr_exp, i2c_exp, tmo_exp, off_exp;
  assign pwr_exp = tick && (timer_q == TW'(PWR_DLY_TICKS - 1));
  assign i2c_exp = tick && (timer_q == TW'(I2C_DLY_TICKS - 1));
  assign tmo_exp = tick && (timer_q == TW'(INIT_TMO_TICKS - 1));
  assign off_exp = tick && (timer_q == TW'(OFF_TICKS - 1));

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_PWR_ON;
      end
      S_PWR_ON: begin
        if (!enable)      state_d = S_PWR_OFF;
        else if (pwr_exp) state_d = S_I2C_REL;
      end
      S_I2C_REL: begin
        if (!enable)      state_d = S_PWR_OFF;
        else if (i2c_exp) state_d = S_INIT;
      end
      S_INIT: begin
        // Abort beats error, error beats done, done beats timeout.
        if (!enable) begin
          state_d = S_PWR_OFF;
        end else if (init_err || (tmo_exp && !init_done)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_PWR_OFF;
          end else begin
            state_d = S_FAULT;
          end
        end else if (init_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) state_d = S_PWR_OFF;
      end
      S_PWR_OFF: begin
        if (off_exp) state_d = enable ? S_PWR_ON : S_IDLE;
      end
      S_FAULT: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Retry count belongs to one bring-up; it is zero whenever we sit in IDLE.
    if (state_d == S_IDLE) retry_d = '0;

    // Only the timed states count; others never run the timer into a wrap.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && (state_q inside {S_PWR_ON, S_I2C_REL, S_INIT, S_PWR_OFF})) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      cam_en_q  <= 1'b0;
      i2c_rel_q <= 1'b0;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      // Outputs are decoded from the next state so they line up with state_q.
      cam_en_q  <= state_d inside {S_PWR_ON, S_I2C_REL, S_INIT, S_RUN};
      i2c_rel_q <= state_d inside {S_I2C_REL, S_INIT, S_RUN};
      start_q   <= (state_q == S_I2C_REL) && (state_d == S_INIT);
      ready_q   <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign cam_en       = cam_en_q;
  assign i2c_areset_n = i2c_rel_q;
  assign init_start   = start_q;
  assign cam_ready    = ready_q;
  assign fault        = fault_q;
  assign retry_cnt    = retry_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cam_bringup_seq.sv
// -----------------------------------------------------------------------------
// tb_cam_bringup_seq
//   Directed scenarios followed by a randomized soak. A cycle model of the
//   bring-up rules (ticks-remaining countdown per timed state) predicts every
//   output; a compare process checks the DUT against it on each negedge.
//   Literal expectations at scenario end pin the model itself.
// -----------------------------------------------------------------------------
module tb_cam_bringup_seq;

  localparam int P_PWR = 4, P_I2C = 3, P_TMO = 5, P_OFF = 2, P_MAXR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_gen = 1'b0, force_tick = 1'b0, tick_rand = 1'b0;
  logic       tick;
  logic       enable = 1'b0, init_done = 1'b0, init_err = 1'b0;
  logic       cam_en, i2c_areset_n, init_start, cam_ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  int tcnt = 0;

  assign tick = tick_gen | force_tick;

  cam_bringup_seq #(
    .PWR_DLY_TICKS(P_PWR), .I2C_DLY_TICKS(P_I2C), .INIT_TMO_TICKS(P_TMO),
    .OFF_TICKS(P_OFF), .MAX_RETRY(P_MAXR)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .init_done(init_done), .init_err(init_err), .cam_en(cam_en),
    .i2c_areset_n(i2c_areset_n), .init_start(init_start),
    .cam_ready(cam_ready), .fault(fault), .retry_cnt(retry_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Tick source: every 4th clk in directed tests, random in the soak.
  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    tick_gen = tick_rand ? ($urandom_range(0, 2) == 0) : (tcnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 powering, 2 i2c released, 3 init, 4 run, 5 off, 6 fault.
  int m_state = 0, m_left = 0, m_retry = 0, m_nxt;
  bit m_start = 0, m_valid = 0, m_wait_over, m_fail;

  function automatic int dur(input int s);
    case (s)
      1: return P_PWR;
      2: return P_I2C;
      3: return P_TMO;
      5: return P_OFF;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_retry = 0; m_start = 0; m_valid = 1;
    end else if (m_valid) begin
      m_nxt = m_state;
      m_wait_over = 0;
      m_fail = 0;
      if (dur(m_state) > 0 && tick) begin
        m_left--;
        m_wait_over = (m_left == 0);
      end
      case (m_state)
        0: if (enable) m_nxt = 1;
        1: if (!enable) m_nxt = 5; else if (m_wait_over) m_nxt = 2;
        2: if (!enable) m_nxt = 5; else if (m_wait_over) m_nxt = 3;
        3: if (!enable) m_nxt = 5;
           else if (init_err) m_fail = 1;
           else if (init_done) m_nxt = 4;
           else if (m_wait_over) m_fail = 1;
        4: if (!enable) m_nxt = 5;
        5: if (m_wait_over) m_nxt = enable ? 1 : 0;
        6: if (!enable) m_nxt = 0;
        default: m_nxt = 0;
      endcase
      if (m_fail) begin
        if (m_retry < P_MAXR) begin m_retry++; m_nxt = 5; end
        else m_nxt = 6;
      end
      m_start = (m_state == 2) && (m_nxt == 3);
      if (m_nxt != m_state) m_left = dur(m_nxt);
      if (m_nxt == 0) m_retry = 0;
      m_state = m_nxt;
    end
  end

  // ---------------- compare + monitor ----------------
  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {(m_state inside {1, 2, 3, 4}), (m_state inside {2, 3, 4}), m_start,
               (m_state == 4), (m_state == 6), 2'(m_retry), 3'(m_state)};
      act_v = {cam_en, i2c_areset_n, init_start, cam_ready, fault, retry_cnt, state_o};
      check("model {en,rel,start,rdy,flt,retry,state}", 32'(act_v), 32'(exp_v));
    end
    if (init_start === 1'b1) n_starts++;
  end

  // ---------------- helpers ----------------
  task automatic wait_state(input int s, input int max_cyc);
    int n = 0;
    while (state_o !== 3'(s) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_state_%0d", s), 32'(state_o), 32'(s));
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; init_done = 1'b0; init_err = 1'b0; force_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_starts = 0;
  endtask

  task automatic pulse_init(input logic d, input logic e);
    init_done = d; init_err = e;
    @(negedge clk);
    init_done = 1'b0; init_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("reset_state", 32'(state_o), 0);
    check("reset_outputs", 32'({cam_en, i2c_areset_n, init_start, cam_ready, fault, retry_cnt}), 0);

    // Nominal bring-up.
    enable = 1'b1;
    @(negedge clk);
    check("cam_en_one_cycle_after_enable", 32'(cam_en), 1);
    wait_state(3, 200);
    wait_ticks(2);
    pulse_init(1'b1, 1'b0);
    check("nominal_state_run", 32'(state_o), 4);
    check("nominal_ready", 32'(cam_ready), 1);
    check("nominal_retry", 32'(retry_cnt), 0);
    check("nominal_starts", 32'(n_starts), 1);

    // Timeouts until fault.
    do_reset();
    enable = 1'b1;
    wait_state(6, 2000);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_retry", 32'(retry_cnt), 2);
    check("tmo_starts", 32'(n_starts), 3);
    enable = 1'b0;
    @(negedge clk);
    check("fault_exit_idle", 32'(state_o), 0);
    check("fault_exit_retry", 32'(retry_cnt), 0);

    // Error on first attempt, success on second.
    do_reset();
    enable = 1'b1;
    wait_state(3, 200);
    pulse_init(1'b0, 1'b1);
    check("err_to_off", 32'(state_o), 5);
    wait_state(3, 300);
    pulse_init(1'b1, 1'b0);
    check("err_then_run", 32'(state_o), 4);
    check("err_then_retry", 32'(retry_cnt), 1);

    // Error and done together: error wins.
    do_reset();
    enable = 1'b1;
    wait_state(3, 200);
    pulse_init(1'b1, 1'b1);
    check("err_done_same_cycle_state", 32'(state_o), 5);
    check("err_done_same_cycle_retry", 32'(retry_cnt), 1);

    // Done on the timeout tick: done wins.
    do_reset();
    enable = 1'b1;
    wait_state(3, 200);
    wait_ticks(4);
    force_tick = 1'b1;
    pulse_init(1'b1, 1'b0);
    force_tick = 1'b0;
    check("done_beats_timeout", 32'(state_o), 4);

    // Abort during I2C_REL.
    do_reset();
    enable = 1'b1;
    wait_state(2, 200);
    enable = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state_o), 5);
    check("abort_i2c_reset", 32'(i2c_areset_n), 0);
    check("abort_retry", 32'(retry_cnt), 0);
    wait_state(0, 100);
    check("abort_no_start", 32'(n_starts), 0);

    // Shutdown from RUN, re-enable during PWR_OFF.
    do_reset();
    enable = 1'b1;
    wait_state(3, 200);
    pulse_init(1'b1, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check("shutdown_outputs", 32'({cam_en, cam_ready}), 0);
    enable = 1'b1;
    wait_state(1, 100);

    // Reset in INIT with tick and done both high.
    do_reset();
    enable = 1'b1;
    wait_state(3, 200);
    reset = 1'b1; force_tick = 1'b1; init_done = 1'b1;
    @(negedge clk);
    check("reset_in_init_state", 32'(state_o), 0);
    check("reset_in_init_outputs", 32'({cam_en, i2c_areset_n, init_start, cam_ready, fault}), 0);
    reset = 1'b0; force_tick = 1'b0; init_done = 1'b0; enable = 1'b0;

    // Randomized soak, checked cycle by cycle against the model.
    tick_rand = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      init_done = ($urandom_range(0, 14) == 0);
      init_err  = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0; init_done = 1'b0; init_err = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_bringup_seq.md
Name: cam_bringup_seq

Overview:
- Camera bring-up sequencer. Replaces the free-running seconds-based enable chain with a supervised state machine.
- Controls the order of events: camera power enable, then I2C master reset release, then a camera-register init request to the I2C config block.
- Waits for init completion and reports `cam_ready`. On init error or timeout it power-cycles the camera and retries, up to a limit, then latches a fault.
- Sits next to the clock/reset generator. Consumes its 400kHz strobe as the timebase.

Parameters:
- PWR_DLY_TICKS, 800000, ticks from `cam_en` rise to `i2c_areset_n` release (2 s at 400kHz); must be >=1
- I2C_DLY_TICKS, 800000, ticks from I2C reset release to `init_start` (2 s); must be >=1
- INIT_TMO_TICKS, 400000, max ticks spent waiting for `init_done`/`init_err` (1 s); must be >=1
- OFF_TICKS, 40000, power-off hold time before re-power or idle (100 ms); must be >=1
- MAX_RETRY, 3, number of re-power attempts allowed after the first failure
- TW, derived, timer width = `$clog2(max of the four *_TICKS)+1`
- RW, derived, retry counter width = `$clog2(MAX_RETRY+1)`

Ports:
- clk  in  1  system clock (100MHz)
- reset  in  1  synchronous, active-high reset
- tick  in  1  400kHz strobe, one `clk` cycle wide
- enable  in  1  level; 1 = bring camera up and keep it up
- init_done  in  1  pulse from I2C config block: register init finished OK
- init_err  in  1  pulse from I2C config block: NACK/abort during init
- cam_en  out  1  camera power/enable pin drive
- i2c_areset_n  out  1  I2C master reset, active-low
- init_start  out  1  one-cycle pulse requesting I2C register init
- cam_ready  out  1  camera initialised and streaming allowed
- fault  out  1  retries exhausted; sticky until `enable` drops
- retry_cnt  out  RW  number of retries consumed in the current bring-up
- state_o  out  3  current state code, for debug/ILA

Behaviour:
- Decided: one clock `clk`; `reset` is synchronous, active-high.
- All outputs are registered. Reset values: state IDLE, all outputs 0, timer 0.
- State codes: IDLE=0, PWR_ON=1, I2C_REL=2, INIT=3, RUN=4, PWR_OFF=5, FAULT=6. Codes 7 and unused fall back to IDLE.
- Timer: cleared on every state change. Increments only on cycles with `tick`=1. A "wait N ticks" exits on the clk edge where the Nth tick since entry is sampled, i.e. the state changes in the cycle after that tick.
- Output decode per state (`cam_en`/`i2c_areset_n`/`cam_ready`/`fault`):
  - IDLE 0/0/0/0
  - PWR_ON 1/0/0/0
  - I2C_REL 1/1/0/0
  - INIT 1/1/0/0
  - RUN 1/1/1/0
  - PWR_OFF 0/0/0/0
  - FAULT 0/0/0/1
- IDLE: `retry_cnt` <= 0. `enable`=1 -> PWR_ON.
- PWR_ON: after PWR_DLY_TICKS -> I2C_REL.
- I2C_REL: after I2C_DLY_TICKS -> INIT. `init_start`=1 for exactly the first cycle in INIT, and never otherwise.
- INIT, priority order:
  1. `init_err` -> retry path.
  2. `init_done` -> RUN.
  3. Timeout (INIT_TMO_TICKS reached) -> retry path.
  - `init_done` and the timeout tick in the same cycle: done wins.
  - `init_err` and `init_done` in the same cycle: error wins.
  - Retry path: if `retry_cnt` < MAX_RETRY, then `retry_cnt`++ and go to PWR_OFF; else go to FAULT (`retry_cnt` holds).
- RUN: `init_done`/`init_err` are ignored. `enable`=0 -> PWR_OFF.
- PWR_OFF: after OFF_TICKS, `enable`=1 -> PWR_ON, `enable`=0 -> IDLE. `enable` is sampled at the exit edge.
- FAULT: stays until `enable`=0, then -> IDLE.
- `enable`=0 in PWR_ON, I2C_REL or INIT -> PWR_OFF on the next edge. No retry is counted. This takes priority over every INIT event in the same cycle.
- `tick` and inputs are honoured in the same cycle as a state entry only via the rules above. The timer is zero on entry, so a tick in the entry cycle counts as tick 1.
- `reset` mid-operation forces IDLE and all outputs 0 on the next edge, regardless of `tick`. `cam_en` therefore drops within one cycle.

Test Plan:
(Sim params: PWR_DLY=4, I2C_DLY=3, INIT_TMO=5, OFF=2, MAX_RETRY=2; `tick` every 4 clks.)
- Nominal: `enable`=1, `init_done` pulsed 2 ticks into INIT -> `cam_en` up 1 cycle after `enable`; `i2c_areset_n` up after the 4th tick; single `init_start` after the 3rd further tick; `cam_ready`=1, `state_o`=4, `retry_cnt`=0.
- Timeout retries: never pulse `init_done` -> INIT exits after 5 ticks; PWR_OFF for 2 ticks (`cam_en`=0); 3 `init_start` pulses in total; then `fault`=1, `state_o`=6, `retry_cnt`=2; dropping `enable` -> IDLE, `retry_cnt`=0.
- Error then success: `init_err` on 1st attempt, `init_done` on 2nd -> one PWR_OFF pass, RUN with `retry_cnt`=1. Same-cycle `init_err`+`init_done` -> treated as error.
- Abort: drop `enable` during I2C_REL -> PWR_OFF next cycle, `i2c_areset_n`=0, no `init_start`, `retry_cnt` unchanged, IDLE after 2 ticks.
- Shutdown from RUN: `enable`=0 -> `cam_ready` and `cam_en` fall next cycle; re-assert `enable` during PWR_OFF -> PWR_ON after 2 ticks.
- Reset in INIT with `tick` and `init_done` both high in that cycle -> all outputs 0, `state_o`=0 next cycle; no `cam_ready`.
